// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared definitions for button event consumers: FSM state
//                encoding, default press/gap lengths and timer sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Default held-press length that classifies a long press (clk cycles)
    localparam int unsigned c_long_cycles_dflt = 50_000_000;
    // Default maximum release gap that joins two presses (clk cycles)
    localparam int unsigned c_gap_cycles_dflt  = 15_000_000;

    // Button classifier states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT   = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_HOLD   = 3'd4
    } btn_state_e;

    // Timer width covering the larger terminal count; never less than 1 bit
    function automatic int unsigned timer_width(input int unsigned long_c,
                                                input int unsigned gap_c);
        int unsigned max_c;
        int unsigned w;
        max_c = (long_c > gap_c) ? long_c : gap_c;
        w     = $clog2(max_c);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_decoder
//  Description : Classifies a debounced button level into single click,
//                double click and long press pulses, and counts events.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = c_long_cycles_dflt,
    parameter int unsigned GAP_CYCLES  = c_gap_cycles_dflt
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ok,
    output logic       click,
    output logic       dbl_click,
    output logic       long_press,
    output logic       busy,
    output logic [7:0] evt_cnt
);

    localparam int unsigned     c_tw        = timer_width(LONG_CYCLES, GAP_CYCLES);
    // Terminal values: the timer reads TERM-1 during the last cycle of a phase
    localparam logic [c_tw-1:0] c_long_last = c_tw'(LONG_CYCLES - 1);
    localparam logic [c_tw-1:0] c_gap_last  = c_tw'(GAP_CYCLES - 1);

    logic            pressed_q;
    btn_state_e      state_q,      state_d;
    logic [c_tw-1:0] timer_q,      timer_d;
    logic            click_q,      click_d;
    logic            dbl_click_q,  dbl_click_d;
    logic            long_press_q, long_press_d;
    logic [7:0]      evt_cnt_q,    evt_cnt_d;

    // Input stage: the FSM only ever looks at this registered, active-high level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed_q <= 1'b0;
        end else begin
            pressed_q <= ~btn_ok;
        end
    end

    // Next-state, timer and event decode
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + 1'b1;
        click_d      = 1'b0;
        dbl_click_d  = 1'b0;
        long_press_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // No terminal count here, so the timer is parked at zero
                timer_d = '0;
                if (pressed_q) begin
                    state_d = ST_PRESS1;
                end
            end
            ST_PRESS1: begin
                if (!pressed_q) begin
                    state_d = ST_WAIT;
                end else if (timer_q == c_long_last) begin
                    long_press_d = 1'b1;
                    state_d      = ST_HOLD;
                end
            end
            ST_WAIT: begin
                // A re-press wins over a coincident gap timeout
                if (pressed_q) begin
                    state_d = ST_PRESS2;
                end else if (timer_q == c_gap_last) begin
                    click_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (!pressed_q) begin
                    dbl_click_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (timer_q == c_long_last) begin
                    long_press_d = 1'b1;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Long press already reported; just wait for release silently
                timer_d = '0;
                if (!pressed_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Every state entry restarts the phase timer
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    // Event counter advances the cycle after any event pulse, wrapping at 8 bits
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (click_q || dbl_click_q || long_press_q) begin
            evt_cnt_d = evt_cnt_q + 8'd1;
        end
    end

    // State, timer, registered event pulses and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            click_q      <= 1'b0;
            dbl_click_q  <= 1'b0;
            long_press_q <= 1'b0;
            evt_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            click_q      <= click_d;
            dbl_click_q  <= dbl_click_d;
            long_press_q <= long_press_d;
            evt_cnt_q    <= evt_cnt_d;
        end
    end

    assign click      = click_q;
    assign dbl_click  = dbl_click_q;
    assign long_press = long_press_q;
    assign busy       = (state_q != ST_IDLE);
    assign evt_cnt    = evt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_event_decoder
//  Description : Directed self-checking bench for btn_event_decoder with
//                LONG_CYCLES=8, GAP_CYCLES=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_ok;
    logic       click;
    logic       dbl_click;
    logic       long_press;
    logic       busy;
    logic [7:0] evt_cnt;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int base   = 0;
    int n_click, n_dbl, n_long, multi;
    int at_click, at_dbl, at_long;
    int tot_click;

    btn_event_decoder #(
        .LONG_CYCLES (8),
        .GAP_CYCLES  (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_ok     (btn_ok),
        .click      (click),
        .dbl_click  (dbl_click),
        .long_press (long_press),
        .busy       (busy),
        .evt_cnt    (evt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start a new scenario: edge numbering restarts so the next edge is 1
    task automatic clr();
        n_click  = 0; n_dbl  = 0; n_long  = 0; multi = 0;
        at_click = -1; at_dbl = -1; at_long = -1;
        base     = cyc;
    endtask

    // Hold btn_ok at b for n edges, observing pulses 1 time unit after each edge
    task automatic run(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            btn_ok = b;
            @(posedge clk);
            #1;
            cyc++;
            if (click)      begin n_click++; if (at_click < 0) at_click = cyc - base; end
            if (dbl_click)  begin n_dbl++;   if (at_dbl   < 0) at_dbl   = cyc - base; end
            if (long_press) begin n_long++;  if (at_long  < 0) at_long  = cyc - base; end
            if ((click & dbl_click) | (click & long_press) | (dbl_click & long_press)) multi++;
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives
    task automatic do_reset(input logic b);
        btn_ok = b;
        rst_n  = 1'b0;
        #2;
        check("rst_click", click,      0);
        check("rst_dbl",   dbl_click,  0);
        check("rst_long",  long_press, 0);
        check("rst_busy",  busy,       0);
        check("rst_evt",   evt_cnt,    0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc += 2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_ok = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc = 2;
        check("init_click", click,      0);
        check("init_dbl",   dbl_click,  0);
        check("init_long",  long_press, 0);
        check("init_busy",  busy,       0);
        check("init_evt",   evt_cnt,    0);
        rst_n = 1'b1;

        // Single click: press 3, release 10; WAIT entered at edge 5, click at 9
        clr(); run(1'b0, 3); run(1'b1, 10);
        check("click_cnt",   n_click,  1);
        check("click_at",    at_click, 9);
        check("click_nodbl", n_dbl,    0);
        check("click_nolng", n_long,   0);
        check("click_evt",   evt_cnt,  1);
        check("click_busy",  busy,     0);
        check("click_multi", multi,    0);

        // Press of 8 edges is one short of long: click, WAIT at 10, click at 14
        do_reset(1'b1);
        clr(); run(1'b0, 8); run(1'b1, 12);
        check("p8_nolong", n_long,   0);
        check("p8_click",  n_click,  1);
        check("p8_at",     at_click, 14);

        // Long press: held 20, long_press 9 edges after first low sample (edge 10)
        do_reset(1'b1);
        clr(); run(1'b0, 3);
        check("long_busy", busy, 1);
        run(1'b0, 17);
        check("long_cnt", n_long,  1);
        check("long_at",  at_long, 10);
        run(1'b1, 6);
        check("long_rel_cnt",   n_long,  1);
        check("long_rel_click", n_click, 0);
        check("long_rel_dbl",   n_dbl,   0);
        check("long_rel_busy",  busy,    0);
        check("long_evt",       evt_cnt, 1);

        // Double click: press 3, release 2, press 3, release; dbl at edge 10
        do_reset(1'b1);
        clr(); run(1'b0, 3); run(1'b1, 2); run(1'b0, 3); run(1'b1, 10);
        check("dbl_cnt",   n_dbl,   1);
        check("dbl_at",    at_dbl,  10);
        check("dbl_click", n_click, 0);
        check("dbl_evt",   evt_cnt, 1);
        check("dbl_multi", multi,   0);

        // Second press held to long: PRESS2 at 7, long only at 15
        do_reset(1'b1);
        clr(); run(1'b0, 3); run(1'b1, 2); run(1'b0, 12); run(1'b1, 6);
        check("p2l_long",  n_long,  1);
        check("p2l_at",    at_long, 15);
        check("p2l_dbl",   n_dbl,   0);
        check("p2l_click", n_click, 0);
        check("p2l_evt",   evt_cnt, 1);

        // Re-press coincides with gap timeout: no click, dbl at edge 11
        do_reset(1'b1);
        clr(); run(1'b0, 3); run(1'b1, 4); run(1'b0, 2); run(1'b1, 8);
        check("race_click", n_click, 0);
        check("race_dbl",   n_dbl,   1);
        check("race_at",    at_dbl,  11);
        check("race_evt",   evt_cnt, 1);

        // Reset during WAIT drops the pending click and clears the counter
        clr(); run(1'b0, 3); run(1'b1, 2);
        check("wrst_busy", busy, 1);
        do_reset(1'b1);
        clr(); run(1'b1, 10);
        check("wrst_click", n_click, 0);
        check("wrst_evt",   evt_cnt, 0);
        check("wrst_busy2", busy,    0);

        // Reset released with button held: new press, long at edge 10
        do_reset(1'b0);
        clr(); run(1'b0, 1);
        check("hrst_busy0", busy, 0);
        run(1'b0, 1);
        check("hrst_busy1", busy, 1);
        run(1'b0, 10);
        check("hrst_long", n_long,  1);
        check("hrst_at",   at_long, 10);
        run(1'b1, 4);

        // 256 single clicks wrap the counter back to zero
        do_reset(1'b1);
        tot_click = 0;
        for (int k = 0; k < 256; k++) begin
            clr(); run(1'b0, 3); run(1'b1, 10);
            tot_click += n_click;
            if (k == 254) check("wrap_255", evt_cnt, 255);
        end
        check("wrap_clicks", tot_click, 256);
        check("wrap_zero",   evt_cnt,   0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
